// File: rtl/seg_display_controller_if.sv
// Bus-side signals of the 4-digit 7-segment display peripheral: the decoded
// write strobe and data going in, the multiplexed segment/anode drive coming out.
interface seg_display_controller_if;
    logic        writeEnable;
    logic        readEnable;
    logic [31:0] writeData;
    logic [29:0] memAddress;
    logic [6:0]  seg;
    logic [3:0]  an;

    modport master (
        output writeEnable, readEnable, writeData, memAddress,
        input  seg, an
    );

    modport slave (
        input  writeEnable, readEnable, writeData, memAddress,
        output seg, an
    );
endinterface

// File: rtl/seg_display_controller.sv
// 4-digit multiplexed 7-segment display with hex or double-dabble decimal mode.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (rightmost always lit).
module seg_display_controller #(
    parameter int REFRESH_BITS = 18,
    parameter int MAX_DEC      = 9999
) (
    input logic                     clk,
    input logic                     rst,
    seg_display_controller_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [15:0]             value_q,     value_d;
    logic                    mode_q,      mode_d;
    logic                    start_q,     start_d;
    logic [15:0]             digits_q,    digits_d;
    logic [0:0]              state_q,     state_d;
    logic [15:0]             bin_q,       bin_d;
    logic [15:0]             bcd_q,       bcd_d;
    logic [3:0]              shift_cnt_q, shift_cnt_d;
    logic [REFRESH_BITS-1:0] scan_q,      scan_d;
    logic [3:0]              an_q,        an_d;
    logic [6:0]              seg_q,       seg_d;

    logic [31:0] shifted;
    logic [1:0]  sel;
    logic [3:0]  nib;
    logic        blank;

    // The device is write-only and single-register; these inputs are intentionally dropped.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.readEnable, bus.memAddress, bus.writeData[31:17]};

    function automatic logic [15:0] saturate(input logic [15:0] v);
        if (32'(v) > 32'(MAX_DEC)) return 16'(MAX_DEC);
        return v;
    endfunction

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Write capture and conversion FSM. A write always wins over an in-flight or
    // completing conversion; a decimal write starts conversion on the following edge.
    always_comb begin
        value_d     = value_q;
        mode_d      = mode_q;
        start_d     = start_q;
        digits_d    = digits_q;
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        shift_cnt_d = shift_cnt_q;
        shifted     = {add3(bcd_q), bin_q} << 1;

        if (bus.writeEnable) begin
            value_d     = bus.writeData[15:0];
            mode_d      = bus.writeData[16];
            state_d     = IDLE;
            shift_cnt_d = 4'd0;
            start_d     = bus.writeData[16];
            if (!bus.writeData[16]) digits_d = bus.writeData[15:0];
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_q) begin
                        start_d = 1'b0;
                        if (mode_q) begin
                            state_d     = CONV;
                            bin_d       = saturate(value_q);
                            bcd_d       = 16'd0;
                            shift_cnt_d = 4'd0;
                        end
                    end
                end
                default: begin
                    bcd_d       = shifted[31:16];
                    bin_d       = shifted[15:0];
                    shift_cnt_d = shift_cnt_q + 4'd1;
                    if (shift_cnt_q == 4'd15) begin
                        state_d  = IDLE;
                        digits_d = shifted[31:16];
                    end
                end
            endcase
        end
    end

    // Scan: anode and segments are registered together from the same select.
    always_comb begin
        scan_d = scan_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
        sel    = scan_q[REFRESH_BITS-1 -: 2];
        nib    = digits_q[{sel, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank  = (sel != 2'd0) && ((digits_q >> {sel, 2'b00}) == 16'd0);
`else
        blank  = 1'b0;
`endif
        if (blank) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end else begin
            an_d  = ~(4'b0001 << sel);
            seg_d = glyph(nib);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q     <= 16'd0;
            mode_q      <= 1'b0;
            start_q     <= 1'b0;
            digits_q    <= 16'd0;
            state_q     <= IDLE;
            bin_q       <= 16'd0;
            bcd_q       <= 16'd0;
            shift_cnt_q <= 4'd0;
            scan_q      <= '0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
        end else begin
            value_q     <= value_d;
            mode_q      <= mode_d;
            start_q     <= start_d;
            digits_q    <= digits_d;
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            shift_cnt_q <= shift_cnt_d;
            scan_q      <= scan_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_display_controller.sv
// Randomized bench for seg_display_controller (REFRESH_BITS=4) against a
// cycle-level behavioural model of the displayed digits.
module tb_seg_display_controller;

    logic clk;
    logic rst;
    seg_display_controller_if bus();

    seg_display_controller #(.REFRESH_BITS(4), .MAX_DEC(9999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: what the display shows, plus a pending decimal result and its countdown.
    int          m_cnt;
    int unsigned m_disp;
    int unsigned m_target;
    int          m_pend;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int unsigned to_bcd(input int unsigned n);
        return ((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + (n % 10);
    endfunction

    task automatic model_reset();
        m_cnt    = 0;
        m_disp   = 0;
        m_target = 0;
        m_pend   = 0;
        exp_an   = 4'b1111;
        exp_seg  = 7'b1111111;
    endtask

    task automatic model_edge(input logic w, input logic [31:0] d);
        int k;
        int unsigned v;
        k = m_cnt / 4;
        exp_an  = 4'b1111;
        exp_an[k] = 1'b0;
        exp_seg = GLYPH[(m_disp >> (4 * k)) % 16];
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && (m_disp >> (4 * k)) == 0) begin
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
        end
`endif
        m_cnt = (m_cnt + 1) % 16;
        if (w) begin
            v = d[15:0];
            if (d[16]) begin
                if (v > 9999) v = 9999;
                m_target = to_bcd(v);
                m_pend   = 17;
            end else begin
                m_disp = v;
                m_pend = 0;
            end
        end else if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) m_disp = m_target;
        end
    endtask

    task automatic step(input logic w, input logic [31:0] d);
        bus.writeEnable = w;
        bus.writeData   = d;
        bus.readEnable  = 1'($urandom);
        bus.memAddress  = 30'($urandom);
        @(posedge clk);
        model_edge(w, d);
        #1;
        check_eq("an", 32'(bus.an), 32'(exp_an));
        check_eq("seg", 32'(bus.seg), 32'(exp_seg));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'($urandom) & 32'hFFFE_FFFF);
    endtask

    task automatic hold_reset(input int n);
        rst = 1'b0;
        bus.writeEnable = 1'b0;
        #1;
        model_reset();
        check_eq("rst_an", 32'(bus.an), 32'(exp_an));
        check_eq("rst_seg", 32'(bus.seg), 32'(exp_seg));
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_an", 32'(bus.an), 32'h0000_000F);
            check_eq("rst_seg", 32'(bus.seg), 32'h0000_007F);
        end
        rst = 1'b1;
    endtask

    initial begin
        logic w;
        logic [31:0] d;
        rst             = 1'b1;
        bus.writeEnable = 1'b0;
        bus.readEnable  = 1'b0;
        bus.writeData   = 32'd0;
        bus.memAddress  = 30'd0;
        #2;
        hold_reset(5);
        idle(20);

        step(1'b1, 32'h0000_1A2F);  // hex
        idle(20);
        step(1'b1, 32'h0001_04D2);  // decimal 1234
        idle(40);
        step(1'b1, 32'h0001_FFFF);  // saturates to 9999
        idle(40);
        step(1'b1, 32'h0001_04D2);  // abort: second write mid-conversion
        idle(5);
        step(1'b1, 32'h0001_0007);
        idle(40);
        step(1'b1, 32'h0001_0929);  // hex write aborts a conversion
        idle(3);
        step(1'b1, 32'h0000_BEEF);
        idle(40);
        step(1'b1, 32'h0001_04D2);  // write coincides with completion edge
        idle(16);
        step(1'b1, 32'h0001_002A);
        idle(40);
        step(1'b1, 32'h0001_0000);  // decimal zero
        idle(40);

        step(1'b1, 32'h0001_04D2);  // reset mid-conversion
        idle(7);
        hold_reset(3);
        idle(20);
        step(1'b1, 32'h0001_0007);
        idle(40);

        for (int i = 0; i < 2500; i++) begin
            w = ($urandom_range(0, 14) == 0);
            d = 32'($urandom);
            case ($urandom_range(0, 3))
                0: d[15:0] = 16'($urandom_range(0, 99));
                1: d[15:0] = 16'($urandom_range(9990, 10010));
                default: ;
            endcase
            step(w, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_display_controller.md
Name: seg_display_controller

Overview:
Memory-mapped 4-digit 7-segment display peripheral downstream of the address decoder. It consumes the LED/display write strobe and write data, and drives time-multiplexed active-low segments and anodes on the board. A write selects hex mode or decimal mode. Decimal values are converted by a sequential double-dabble FSM before display.

Parameters:
- REFRESH_BITS, 18, width of the free-running scan counter. The top 2 bits select the digit. Full scan period is 2^REFRESH_BITS cycles.
- MAX_DEC, 9999, saturation limit applied in decimal mode.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- writeEnable  input  1  write strobe, already qualified by the decoder select
- readEnable  input  1  ignored; the device is output-only
- writeData  input  32  [15:0] value; [16] mode (0 = hex, 1 = decimal); [31:17] ignored
- memAddress  input  30  ignored; a single register
- seg  output  7  active-low segments, seg[0]=a … seg[6]=g
- an  output  4  active-low anodes, an[0] = rightmost digit

Behaviour:
- Reset, while rst=0:
  - an=4'b1111, seg=7'b1111111.
  - Value, mode and digit registers = 0; scan counter = 0; FSM in IDLE.
- After reset is released, the display shows "0000".
- Write capture: on a rising edge with writeEnable=1, latch value=writeData[15:0] and mode=writeData[16].
- Hex mode:
  - Digit registers load value nibbles on the same edge.
  - Visible on the next scan of each digit.
- Decimal mode:
  - Operand = min(value, MAX_DEC).
  - FSM: IDLE -> CONV. CONV runs 16 shift cycles, with add-3 on any BCD nibble ≥5 before each shift.
  - On the 16th shift the BCD result goes to the digit registers and the FSM returns to IDLE.
  - Digit registers update exactly 17 clock edges after the write edge.
  - Old digits stay displayed during CONV; no partial results ever reach the digit registers.
- Write during CONV: abort and restart with the new operand; the last write wins. A hex write during CONV also aborts and loads immediately.
- Simultaneous write and conversion completion: the write wins; the completed result is discarded.
- Scan:
  - The counter increments every cycle and wraps from all-ones to 0.
  - sel = counter[REFRESH_BITS-1 -: 2]; sel=k drives an[k]=0 and all other anodes to 1.
  - an and seg are both registered from the same edge, one cycle after sel changes, so there is no ghosting.
- Glyphs (seg, active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-conversion: the conversion is aborted and the display returns to "0000".

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: leading zero digits, in both modes, are blanked. In the blanked digit's scan slot, seg=1111111 and an=1111. The rightmost digit is never blanked, so value 0 shows a single "0". Blanking is computed from the digit registers, so it follows the same update latency.
- Undefined: all four digits are always lit, including leading zeros.

Test Plan:
- Reset, sim with REFRESH_BITS=4:
  - Stimulus: hold rst=0 for 5 cycles, then release.
  - Response: an=1111 and seg=1111111 during reset. After release, each of an=1110/1101/1011/0111 is seen with seg=1000000.
- Hex write:
  - Stimulus: writeEnable pulse with writeData=0x0000_1A2F.
  - Response: next scan shows an=1110 seg=0001110, an=1101 seg=0100100, an=1011 seg=0001000, an=0111 seg=1111001.
- Decimal write:
  - Stimulus: writeData=0x0001_04D2 (1234).
  - Response: digit registers stay at the old value through edge 16 and hold 4,3,2,1 at edge 17. Scan shows 0011001, 0110000, 0100100, 1111001.
- Saturation:
  - Stimulus: writeData=0x0001_FFFF.
  - Response: all four digits show 9 (0010000) after 17 cycles.
- Abort and restart:
  - Stimulus: decimal 1234, then 0x0001_0007 at cycle 5 of CONV.
  - Response: the display goes from its old value directly to 0007, 17 cycles after the second write; 1234 never appears.
- Reset mid-conversion:
  - Stimulus: assert rst=0 at cycle 8 of CONV for 1234.
  - Response: outputs go to the reset values immediately (asynchronous reset); after release the display shows "0000".
  - With LEADING_ZERO_BLANK_EN defined: after release only an=1110 lights (seg=1000000). A following decimal 7 shows digits 3..1 blanked.
